// File: rtl/memory_arbiter_if.sv
// Bundle between the RAM arbiter, its three requesters (coherence data side,
// two instruction caches) and the single-port RAM.
interface memory_arbiter_if #(
   parameter int CPUS = 2
);
   // Data side: wait_in is 0 for exactly one cycle per completed word.
   // Instruction side: iwait[x] is 0 for exactly one cycle per fetched word.
   // RAM side: a word completes in the cycle ramstate reads ACCESS.
   logic                       d_ramREN;
   logic                       d_ramWEN;
   logic [31:0]                d_ramaddr;
   logic [31:0]                d_ramstore;
   logic                       wait_in;
   logic [CPUS-1:0]            iREN;
   logic [CPUS-1:0][31:0]      iaddr;
   logic [CPUS-1:0]            iwait;
   logic [CPUS-1:0][31:0]      iload;
   logic                       ramREN;
   logic                       ramWEN;
   logic [31:0]                ramaddr;
   logic [31:0]                ramstore;
   logic [31:0]                ramload;
   logic [1:0]                 ramstate;

   modport slave (
      input  d_ramREN, d_ramWEN, d_ramaddr, d_ramstore,
      input  iREN, iaddr,
      input  ramload, ramstate,
      output wait_in, iwait, iload,
      output ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output d_ramREN, d_ramWEN, d_ramaddr, d_ramstore,
      output iREN, iaddr,
      output ramload, ramstate,
      input  wait_in, iwait, iload,
      input  ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data side has priority, a starvation counter forces
// instruction fetches through, and the two caches alternate round-robin.
module memory_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CPUS         = 2
) (
   input  logic              CLK,
   input  logic              nRST,
   memory_arbiter_if.slave   bus,
   output logic [1:0]        o_state,
   output logic [3:0]        o_dcount,
   output logic              o_rr
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HOLD_D  = 2'd1;
   localparam logic [1:0] ST_HOLD_I0 = 2'd2;
   localparam logic [1:0] ST_HOLD_I1 = 2'd3;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_D    = 2'd1;
   localparam logic [1:0] OWN_I0   = 2'd2;
   localparam logic [1:0] OWN_I1   = 2'd3;

   localparam logic [1:0] RS_FREE   = 2'd0;
   localparam logic [1:0] RS_BUSY   = 2'd1;
   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [1:0]             r_state;
   logic [1:0]             w_next_state;
   logic                   r_rr;
   logic [3:0]             r_dcount;

   logic                   w_dreq;
   logic                   w_anyi;
   logic                   w_starved;
   logic [1:0]             w_owner;
   logic                   w_owner_req;
   logic                   w_done;
   logic                   w_d_done;
   logic                   w_i_done;
   logic                   w_abandon;
   logic [CPUS-1:0]        w_iwait;
   logic [CPUS-1:0][31:0]  w_iload;

   assign w_dreq    = bus.d_ramREN | bus.d_ramWEN;
   assign w_anyi    = |bus.iREN;
   assign w_starved = (r_dcount == LIMIT) && w_anyi;

   // Fresh arbitration only in IDLE; a HOLD state pins the owner until its word ends.
   always_comb begin
      w_owner = OWN_NONE;
      case (r_state)
         ST_IDLE: begin
            if (w_dreq && !w_starved) begin
               w_owner = OWN_D;
            end else if (w_anyi) begin
               if (bus.iREN[r_rr]) begin
                  w_owner = r_rr ? OWN_I1 : OWN_I0;
               end else begin
                  w_owner = r_rr ? OWN_I0 : OWN_I1;
               end
            end
         end
         ST_HOLD_D:  w_owner = OWN_D;
         ST_HOLD_I0: w_owner = OWN_I0;
         ST_HOLD_I1: w_owner = OWN_I1;
         default:    w_owner = OWN_NONE;
      endcase
   end

   always_comb begin
      w_owner_req = 1'b0;
      case (w_owner)
         OWN_D:   w_owner_req = w_dreq;
         OWN_I0:  w_owner_req = bus.iREN[0];
         OWN_I1:  w_owner_req = bus.iREN[1];
         default: w_owner_req = 1'b0;
      endcase
   end

   assign w_done    = (w_owner != OWN_NONE) && (bus.ramstate == RS_ACCESS);
   assign w_d_done  = w_done && (w_owner == OWN_D);
   assign w_i_done  = w_done && ((w_owner == OWN_I0) || (w_owner == OWN_I1));
   assign w_abandon = (r_state != ST_IDLE) && !w_owner_req && !w_done;

   // Write wins when the data side raises both strobes.
   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = 32'h0;
      bus.ramstore = 32'h0;
      case (w_owner)
         OWN_D: begin
            bus.ramWEN   = bus.d_ramWEN;
            bus.ramREN   = bus.d_ramREN & ~bus.d_ramWEN;
            bus.ramaddr  = bus.d_ramaddr;
            bus.ramstore = bus.d_ramstore;
         end
         OWN_I0: begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.iaddr[0];
         end
         OWN_I1: begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.iaddr[1];
         end
         default: begin
            bus.ramREN = 1'b0;
         end
      endcase
   end

   always_comb begin
      w_iwait    = '1;
      w_iload    = '0;
      w_iwait[0] = !(w_i_done && (w_owner == OWN_I0));
      w_iwait[1] = !(w_i_done && (w_owner == OWN_I1));
      if (w_owner == OWN_I0) w_iload[0] = bus.ramload;
      if (w_owner == OWN_I1) w_iload[1] = bus.ramload;
   end

   assign bus.wait_in = !w_d_done;
   assign bus.iwait   = w_iwait;
   assign bus.iload   = w_iload;

   always_comb begin
      w_next_state = ST_IDLE;
      if (!(w_done || w_abandon)) begin
         case (w_owner)
            OWN_D:   w_next_state = ST_HOLD_D;
            OWN_I0:  w_next_state = ST_HOLD_I0;
            OWN_I1:  w_next_state = ST_HOLD_I1;
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // rr points at the cache that did not get the last fetch.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_rr <= 1'b0;
      end else if (w_i_done) begin
         r_rr <= (w_owner == OWN_I0);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_dcount <= 4'd0;
      end else if (w_i_done) begin
         r_dcount <= 4'd0;
      end else if (w_d_done) begin
         if (!w_anyi) begin
            r_dcount <= 4'd0;
         end else if (r_dcount != LIMIT) begin
            r_dcount <= r_dcount + 4'd1;
         end
      end
   end

   assign o_state  = r_state;
   assign o_dcount = r_dcount;
   assign o_rr     = r_rr;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed-vector bench for memory_arbiter: inputs change 1ns after the rising
// edge, outputs are checked on the falling edge against hand-computed values.
module tb_memory_arbiter;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HOLD_D  = 2'd1;
   localparam logic [1:0] ST_HOLD_I0 = 2'd2;

   localparam logic [1:0] RS_FREE   = 2'd0;
   localparam logic [1:0] RS_BUSY   = 2'd1;
   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   logic        CLK;
   logic        nRST;
   logic [1:0]  dbg_state;
   logic [3:0]  dbg_dcount;
   logic        dbg_rr;

   int n_checks = 0;
   int n_errors = 0;

   memory_arbiter_if #(.CPUS(2)) bus ();

   memory_arbiter #(.STARVE_LIMIT(4), .CPUS(2)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .bus      (bus.slave),
      .o_state  (dbg_state),
      .o_dcount (dbg_dcount),
      .o_rr     (dbg_rr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.d_ramREN   = 1'b0;
      bus.d_ramWEN   = 1'b0;
      bus.d_ramaddr  = 32'h0;
      bus.d_ramstore = 32'h0;
      bus.iREN       = 2'b00;
      bus.iaddr[0]   = 32'h0;
      bus.iaddr[1]   = 32'h0;
      bus.ramload    = 32'h0;
      bus.ramstate   = RS_FREE;
   endtask

   task automatic do_reset();
      idle_inputs();
      nRST = 1'b0;
      tick();
      tick();
      nRST = 1'b1;
   endtask

   initial begin
      idle_inputs();
      nRST = 1'b0;
      #2;
      check("rst_ramREN",   32'(bus.ramREN),   32'h0);
      check("rst_ramWEN",   32'(bus.ramWEN),   32'h0);
      check("rst_ramaddr",  bus.ramaddr,       32'h0);
      check("rst_ramstore", bus.ramstore,      32'h0);
      check("rst_wait_in",  32'(bus.wait_in),  32'h1);
      check("rst_iwait",    32'(bus.iwait),    32'h3);
      check("rst_iload0",   bus.iload[0],      32'h0);
      check("rst_iload1",   bus.iload[1],      32'h0);
      check("rst_state",    32'(dbg_state),    32'(ST_IDLE));
      check("rst_dcount",   32'(dbg_dcount),   32'h0);
      tick();
      nRST = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check("idle_strobes", 32'({bus.ramREN, bus.ramWEN}), 32'h0);
         tick();
      end

      // Data read against both instruction requests, two BUSY then ACCESS.
      bus.d_ramREN  = 1'b1;
      bus.d_ramaddr = 32'h100;
      bus.iREN      = 2'b11;
      bus.iaddr[0]  = 32'h40;
      bus.iaddr[1]  = 32'h80;
      bus.ramload   = 32'hCAFE0001;
      for (int c = 0; c < 3; c++) begin
         bus.ramstate = (c == 2) ? RS_ACCESS : RS_BUSY;
         @(negedge CLK);
         check("dpri_addr",   bus.ramaddr,        32'h100);
         check("dpri_ren",    32'(bus.ramREN),    32'h1);
         check("dpri_wait",   32'(bus.wait_in),   (c == 2) ? 32'h0 : 32'h1);
         check("dpri_iwait",  32'(bus.iwait),     32'h3);
         if (c > 0) check("dpri_state", 32'(dbg_state), 32'(ST_HOLD_D));
         tick();
      end
      check("dpri_dcount", 32'(dbg_dcount), 32'h1);

      // Round-robin with single-cycle ACCESS: I0, I1, I0.
      bus.d_ramREN = 1'b0;
      bus.ramstate = RS_ACCESS;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         check("rr_addr",  bus.ramaddr,     (c == 1) ? 32'h80 : 32'h40);
         check("rr_iwait", 32'(bus.iwait),  (c == 1) ? 32'h1 : 32'h2);
         check("rr_iload", (c == 1) ? bus.iload[1] : bus.iload[0], 32'hCAFE0001);
         check("rr_wait_in", 32'(bus.wait_in), 32'h1);
         tick();
      end
      check("rr_dcount_clear", 32'(dbg_dcount), 32'h0);

      // Starvation: continuous data writes, I1 waiting.
      do_reset();
      bus.d_ramWEN   = 1'b1;
      bus.d_ramaddr  = 32'h500;
      bus.d_ramstore = 32'h12345678;
      bus.iREN       = 2'b10;
      bus.iaddr[1]   = 32'h80;
      bus.ramstate   = RS_ACCESS;
      for (int rep = 0; rep < 2; rep++) begin
         for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("stv_dcount", 32'(dbg_dcount),  32'(k));
            check("stv_wen",    32'(bus.ramWEN),  32'h1);
            check("stv_addr",   bus.ramaddr,      32'h500);
            check("stv_wait",   32'(bus.wait_in), 32'h0);
            check("stv_iwait",  32'(bus.iwait),   32'h3);
            tick();
         end
         @(negedge CLK);
         check("stv_sat",     32'(dbg_dcount),  32'h4);
         check("stv_fetch",   bus.ramaddr,      32'h80);
         check("stv_f_wen",   32'(bus.ramWEN),  32'h0);
         check("stv_f_iwait", 32'(bus.iwait),   32'h1);
         check("stv_f_wait",  32'(bus.wait_in), 32'h1);
         tick();
      end
      @(negedge CLK);
      check("stv_cleared", 32'(dbg_dcount), 32'h0);
      check("stv_resume",  32'(bus.wait_in), 32'h0);

      // Both data strobes: write wins.
      do_reset();
      bus.d_ramREN   = 1'b1;
      bus.d_ramWEN   = 1'b1;
      bus.d_ramaddr  = 32'h600;
      bus.d_ramstore = 32'hDEADBEEF;
      @(negedge CLK);
      check("rw_wen",   32'(bus.ramWEN),  32'h1);
      check("rw_ren",   32'(bus.ramREN),  32'h0);
      check("rw_store", bus.ramstore,     32'hDEADBEEF);
      check("rw_wait",  32'(bus.wait_in), 32'h1);
      tick();

      // ERROR holds I0, dropping iREN[0] abandons, pending data follows.
      do_reset();
      bus.iREN     = 2'b01;
      bus.iaddr[0] = 32'h200;
      bus.ramstate = RS_ERROR;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         check("err_iwait", 32'(bus.iwait), 32'h3);
         check("err_addr",  bus.ramaddr,    32'h200);
         check("err_state", 32'(dbg_state), (c == 0) ? 32'(ST_IDLE) : 32'(ST_HOLD_I0));
         tick();
      end
      bus.iREN      = 2'b00;
      bus.d_ramREN  = 1'b1;
      bus.d_ramaddr = 32'h300;
      bus.ramstate  = RS_BUSY;
      @(negedge CLK);
      check("abn_held",  32'(dbg_state),   32'(ST_HOLD_I0));
      check("abn_wait",  32'(bus.wait_in), 32'h1);
      tick();
      @(negedge CLK);
      check("abn_idle",  32'(dbg_state), 32'(ST_IDLE));
      check("abn_grant", bus.ramaddr,    32'h300);
      check("abn_ren",   32'(bus.ramREN), 32'h1);
      check("abn_rr",    32'(dbg_rr),    32'h0);
      tick();
      check("hold_d", 32'(dbg_state), 32'(ST_HOLD_D));
      #2;
      nRST = 1'b0;
      #1;
      check("async_rst", 32'(dbg_state), 32'(ST_IDLE));
      tick();
      nRST = 1'b1;
      idle_inputs();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
